// File: rtl/alu_serial_seq_pkg.sv
// Shared types and helpers for the bit-serial ALU sequencer.
// Provides the ALU control codes, the sequencer state type and the default width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_NOR = 3'b100,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SLT_PASS,
    S_DONE
  } alu_seq_state_t;

  function automatic logic op_is_sub(input logic [2:0] ctl);
    return (ctl == OP_SUB) || (ctl == OP_SLT);
  endfunction

  function automatic logic op_is_arith(input logic [2:0] ctl);
    return (ctl == OP_ADD) || (ctl == OP_SUB);
  endfunction

  function automatic logic op_is_valid(input logic [2:0] ctl);
    return ctl != 3'b101;
  endfunction

  // SLT runs the subtract first; the slice only sees op 111 in the second pass.
  function automatic logic [2:0] slice_op_map(input logic [2:0] ctl);
    return (ctl == OP_SLT) ? OP_SUB : ctl;
  endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// Request/result bus between the datapath and the serial ALU sequencer.
interface alu_serial_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_ctl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, a, b, alu_ctl,
    input  busy, done, result, zero, overflow, carry_out
  );

  modport slave (
    input  start, a, b, alu_ctl,
    output busy, done, result, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_serial_seq_shreg.sv
// Operand rotate-out and result shift-in registers with bit counter.
// Operands rotate so a second pass over the same bits needs no reload.
module alu_serial_shreg
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             y_in,
  output logic             a_nxt,
  output logic             b_nxt,
  output logic [WIDTH-1:0] res_nxt,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CNT_W-1:0] cnt_q;

  assign a_nxt   = a_q[1];
  assign b_nxt   = b_q[1];
  assign res_nxt = {y_in, res_q[WIDTH-1:1]};
  assign last    = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= a_in;
      b_q   <= b_in;
      res_q <= '0;
      cnt_q <= '0;
    end else if (shift) begin
      a_q   <= {a_q[0], a_q[WIDTH-1:1]};
      b_q   <= {b_q[0], b_q[WIDTH-1:1]};
      res_q <= res_nxt;
      cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial MIPS32 ALU sequencer driving one external 1-bit ALU slice.
// Build option: define ALU_SEQ_SLT_FAST_EN to finish SLT without the second pass.
//
//   state      | meaning
//   S_IDLE     | waiting for start; latches operands and control
//   S_RUN      | one operand bit per cycle through the slice, LSB first
//   S_SLT_PASS | SLT second pass, slice op 111 with less = set on bit 0
//   S_DONE     | one-cycle done pulse, result fields valid
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_serial_seq_if.slave        bus,
  output logic                   slice_a,
  output logic                   slice_b,
  output logic                   slice_cin,
  output logic                   slice_less,
  output logic                   slice_add_sub,
  output logic [2:0]             slice_op,
  input  logic                   slice_y,
  input  logic                   slice_cout,
  input  logic                   slice_sum
);

  alu_seq_state_t   state;
  logic [2:0]       ctl_q;
  logic             load, shift, a_nxt, b_nxt, last, y_in;
  logic             ovf_w, set_w;
  logic [WIDTH-1:0] res_nxt;
`ifndef ALU_SEQ_SLT_FAST_EN
  logic             ovf_q;
`endif

  assign load  = (state == S_IDLE) && bus.start;
  assign shift = (state == S_RUN) || (state == S_SLT_PASS);
  assign y_in  = slice_y & op_is_valid(ctl_q);
  // slice_cin still holds the carry into the MSB during the last RUN cycle.
  assign ovf_w = slice_cin ^ slice_cout;
  assign set_w = slice_sum ^ ovf_w;

  alu_serial_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .a_in    (bus.a),
    .b_in    (bus.b),
    .y_in    (y_in),
    .a_nxt   (a_nxt),
    .b_nxt   (b_nxt),
    .res_nxt (res_nxt),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ctl_q         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.carry_out <= 1'b0;
      slice_a       <= 1'b0;
      slice_b       <= 1'b0;
      slice_cin     <= 1'b0;
      slice_less    <= 1'b0;
      slice_add_sub <= 1'b0;
      slice_op      <= '0;
`ifndef ALU_SEQ_SLT_FAST_EN
      ovf_q         <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state         <= S_RUN;
            ctl_q         <= bus.alu_ctl;
            bus.busy      <= 1'b1;
            slice_a       <= bus.a[0];
            slice_b       <= bus.b[0];
            slice_add_sub <= op_is_sub(bus.alu_ctl);
            slice_cin     <= op_is_sub(bus.alu_ctl);
            slice_op      <= slice_op_map(bus.alu_ctl);
            slice_less    <= 1'b0;
          end
        end
        S_RUN: begin
          slice_a   <= a_nxt;
          slice_b   <= b_nxt;
          slice_cin <= slice_cout;
          if (last) begin
            if (ctl_q == OP_SLT) begin
`ifdef ALU_SEQ_SLT_FAST_EN
              state         <= S_DONE;
              bus.done      <= 1'b1;
              bus.result    <= {{(WIDTH-1){1'b0}}, set_w};
              bus.zero      <= ~set_w;
              bus.overflow  <= ovf_w;
              bus.carry_out <= 1'b0;
`else
              state      <= S_SLT_PASS;
              ovf_q      <= ovf_w;
              slice_op   <= OP_SLT;
              slice_less <= set_w;
              slice_cin  <= slice_add_sub;
`endif
            end else begin
              state         <= S_DONE;
              bus.done      <= 1'b1;
              bus.result    <= res_nxt;
              bus.zero      <= (res_nxt == '0);
              bus.overflow  <= op_is_arith(ctl_q) & ovf_w;
              bus.carry_out <= op_is_arith(ctl_q) & slice_cout;
            end
          end
        end
        S_SLT_PASS: begin
          slice_a    <= a_nxt;
          slice_b    <= b_nxt;
          slice_cin  <= slice_cout;
          slice_less <= 1'b0;
`ifndef ALU_SEQ_SLT_FAST_EN
          if (last) begin
            state         <= S_DONE;
            bus.done      <= 1'b1;
            bus.result    <= res_nxt;
            bus.zero      <= (res_nxt == '0);
            bus.overflow  <= ovf_q;
            bus.carry_out <= 1'b0;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_DONE: begin
          state         <= S_IDLE;
          bus.done      <= 1'b0;
          bus.busy      <= 1'b0;
          slice_a       <= 1'b0;
          slice_b       <= 1'b0;
          slice_cin     <= 1'b0;
          slice_less    <= 1'b0;
          slice_add_sub <= 1'b0;
          slice_op      <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit ALU slice.
module tb_alu_serial_seq;

  logic clk = 1'b0;
  logic reset;
  logic slice_a, slice_b, slice_cin, slice_less, slice_add_sub;
  logic [2:0] slice_op;
  logic slice_y, slice_cout, slice_sum;
  int tests = 0;
  int fails = 0;

`ifdef ALU_SEQ_SLT_FAST_EN
  localparam int SLT_CYC = 33;
`else
  localparam int SLT_CYC = 65;
`endif

  alu_serial_seq_if #(.WIDTH(32)) bus ();

  alu_serial_seq #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .slice_a       (slice_a),
    .slice_b       (slice_b),
    .slice_cin     (slice_cin),
    .slice_less    (slice_less),
    .slice_add_sub (slice_add_sub),
    .slice_op      (slice_op),
    .slice_y       (slice_y),
    .slice_cout    (slice_cout),
    .slice_sum     (slice_sum)
  );

  always #5 clk = ~clk;

  // Classic MIPS 1-bit ALU slice.
  logic bb;
  always_comb begin
    bb         = slice_b ^ slice_add_sub;
    slice_sum  = slice_a ^ bb ^ slice_cin;
    slice_cout = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
    case (slice_op)
      3'b000:         slice_y = slice_a & slice_b;
      3'b001:         slice_y = slice_a | slice_b;
      3'b011:         slice_y = slice_a ^ slice_b;
      3'b100:         slice_y = ~(slice_a | slice_b);
      3'b010, 3'b110: slice_y = slice_sum;
      3'b111:         slice_y = slice_less;
      default:        slice_y = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [2:0] ctl, input logic [31:0] er, input logic ez,
                        input logic eo, input logic ec, input int ecyc,
                        input logic [2:0] eop, input logic eas);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ia; bus.b = ib; bus.alu_ctl = ctl;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 2) begin
        chk({tag, "_slice_op"}, slice_op, eop);
        chk({tag, "_add_sub"}, slice_add_sub, eas);
        chk({tag, "_busy"}, bus.busy, 1'b1);
      end
      if (bus.done) begin
        cyc = i;
        break;
      end
    end
    chk({tag, "_done_cycle"}, cyc, ecyc);
    chk({tag, "_result"}, bus.result, er);
    chk({tag, "_zero"}, bus.zero, ez);
    chk({tag, "_overflow"}, bus.overflow, eo);
    chk({tag, "_carry_out"}, bus.carry_out, ec);
    @(negedge clk);
    chk({tag, "_idle_busy"}, bus.busy, 1'b0);
    chk({tag, "_idle_done"}, bus.done, 1'b0);
  endtask

  initial begin
    int cyc;
    int nd;
    int dcyc [3];
    logic seen;

    reset = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.alu_ctl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_zero", bus.zero, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_cout", bus.carry_out, 1'b0);
    chk("rst_slice", {slice_a, slice_b, slice_cin, slice_less, slice_add_sub, slice_op}, 8'h00);
    reset = 1'b0;

    run_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 3'b010, 32'h8000_0000, 0, 1, 0, 33, 3'b010, 0);
    run_op("sub_eq", 32'h5, 32'h5, 3'b110, 32'h0, 1, 0, 1, 33, 3'b110, 1);
    run_op("slt_neg", 32'hFFFF_FFFF, 32'h1, 3'b111, 32'h1, 0, 0, 0, SLT_CYC, 3'b110, 1);
    run_op("slt_ovf", 32'h8000_0000, 32'h1, 3'b111, 32'h1, 0, 1, 0, SLT_CYC, 3'b110, 1);
    run_op("slt_false", 32'h9, 32'h3, 3'b111, 32'h0, 1, 0, 0, SLT_CYC, 3'b110, 1);
    run_op("nor", 32'h0, 32'h0000_FFFF, 3'b100, 32'hFFFF_0000, 0, 0, 0, 33, 3'b100, 0);
    run_op("and", 32'hF0F0_1234, 32'hFF00_00FF, 3'b000, 32'hF000_0034, 0, 0, 0, 33, 3'b000, 0);
    run_op("or", 32'hA000_0001, 32'h0500_0010, 3'b001, 32'hA500_0011, 0, 0, 0, 33, 3'b001, 0);
    run_op("xor", 32'hFFFF_0000, 32'h0F0F_0F0F, 3'b011, 32'hF0F0_0F0F, 0, 0, 0, 33, 3'b011, 0);
    run_op("sub_borrow", 32'h3, 32'h5, 3'b110, 32'hFFFF_FFFE, 0, 0, 0, 33, 3'b110, 1);
    run_op("invalid", 32'h1234_5678, 32'hFFFF_FFFF, 3'b101, 32'h0, 1, 0, 0, 33, 3'b101, 0);

    // start pulsed mid-RUN must not disturb the operation in flight
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h2; bus.b = 32'h3; bus.alu_ctl = 3'b010;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 5) begin
        bus.start = 1'b1; bus.a = 32'hFF; bus.b = 32'hFF; bus.alu_ctl = 3'b110;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        cyc = i;
        break;
      end
    end
    chk("ign_done_cycle", cyc, 33);
    chk("ign_result", bus.result, 32'h5);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | bus.done | bus.busy;
    end
    chk("ign_no_restart", seen, 1'b0);

    // reset in the middle of an ADD
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h1234; bus.b = 32'h1; bus.alu_ctl = 3'b010;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_result", bus.result, 32'h0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_slice", {slice_a, slice_b, slice_cin, slice_add_sub, slice_op}, 7'h00);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | bus.done;
    end
    chk("mid_rst_no_done", seen, 1'b0);

    // start held high: back-to-back ADD 1 + 1
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h1; bus.b = 32'h1; bus.alu_ctl = 3'b010;
    @(posedge clk);
    nd = 0;
    dcyc[0] = 0; dcyc[1] = 0; dcyc[2] = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (bus.done) begin
        chk("b2b_result", bus.result, 32'h2);
        dcyc[nd] = i;
        nd++;
        if (nd == 3) begin
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    chk("b2b_done0", dcyc[0], 33);
    chk("b2b_done1", dcyc[1], 67);
    chk("b2b_done2", dcyc[2], 101);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_stop_busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial sequencer that drives a single 1-bit ALU slice, which computes AND/OR/XOR/NOR/ADD/SUB/SLT, across WIDTH cycles to produce a full-width MIPS32 ALU result. It presents the slice with operand bits LSB-first, supplies `op`, `add_sub`, `carry_in` and `less`, and consumes `Y`, `cout` and `s_addsub`. It sits between the datapath's operand registers and one external slice instance, for the area-reduced multi-cycle core variant.

## Interface
- `WIDTH`, 32, operand/result width; minimum 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `a`, `b`  in  WIDTH  operands, latched on accepted start.
- `alu_ctl`  in  3  000 AND, 001 OR, 011 XOR, 100 NOR, 010 ADD, 110 SUB, 111 SLT; others yield 0.
- `busy`  out  1  high from the cycle after start acceptance through DONE.
- `done`  out  1  one-cycle pulse; result fields valid.
- `result`  out  WIDTH  held until next done.
- `zero`  out  1  result == 0.
- `overflow`  out  1  signed overflow, ADD/SUB/SLT only, else 0.
- `carry_out`  out  1  final carry, ADD/SUB only, else 0.
- `slice_a`, `slice_b`, `slice_cin`, `slice_less`, `slice_add_sub`  out  1  slice drive.
- `slice_op`  out  3  slice op.
- `slice_y`, `slice_cout`, `slice_sum`  in  1  slice returns; combinational from drive in the same cycle.

## Operation
- States: IDLE, RUN, SLT_PASS, DONE.
- IDLE: `start` = 1 latches a, b, alu_ctl. Bit index is set to 0, and the state moves to RUN. `start` in any other state is ignored.
- RUN, bit i = 0..WIDTH-1:
  - `slice_a` = a[i] and `slice_b` = b[i].
  - `slice_add_sub` = 1 for 110/111, else 0.
  - `slice_op` = alu_ctl, with 111 mapped to 110.
  - `slice_cin` = add_sub at i = 0, else the registered `slice_cout` from bit i-1.
  - `slice_less` = 0.
  - `slice_y` shifts into the result register from the MSB end.
- At i = WIDTH-1:
  - overflow = carry_in(bit WIDTH-1) XOR `slice_cout`.
  - set = `slice_sum` XOR overflow.
  - carry_out = `slice_cout`.
  - Next state is SLT_PASS for SLT, else DONE.
- SLT_PASS, bits 0..WIDTH-1: `slice_op` = 111, `slice_less` = set at i = 0, else 0. `slice_y` shifts into result. After bit WIDTH-1 the state moves to DONE.
- DONE: `done` = 1 for one cycle, `zero` updated, then IDLE. `result`, `zero`, `overflow` and `carry_out` change only on entry to DONE.
- Logic ops and invalid codes: `overflow` = 0, `carry_out` = 0.
- Arithmetic is modulo 2^WIDTH. `overflow` is two's-complement signed overflow of a + b or a - b.
- Reset (any state, including mid-RUN): state IDLE, all outputs 0, `slice_*` drive 0, bit index 0.

## Timing
- Reset values: `busy` 0, `done` 0, `result` 0, `zero` 0, `overflow` 0, `carry_out` 0, all `slice_*` outputs 0.
- Start sampled at edge 0; RUN occupies cycles 1..WIDTH; `done` is high in cycle WIDTH+1.
- SLT without the fast option: `done` is high in cycle 2·WIDTH+1.
- `start` held high through DONE is accepted again in the IDLE cycle after DONE. Back-to-back period is WIDTH+2 cycles.
- `slice_*` outputs are driven from registers. The carry register is updated every RUN cycle.

## Configuration
- `ALU_SEQ_SLT_FAST_EN`:
  - Defined: SLT_PASS is skipped. At the end of RUN for SLT, result = {(WIDTH-1)'b0, set} and `done` follows at cycle WIDTH+1.
  - Undefined: the two-pass SLT through slice op 111, as above.
  - Result values are identical in both cases.

## Structure
- Package `alu_pkg`:
  - `alu_op_t` enum for the 3-bit codes.
  - `alu_seq_state_t` enum.
  - `ALU_WIDTH` = 32.
- Sub-module `alu_serial_shreg`: operand shift-out plus result shift-in register with bit counter and last-bit flag. Instantiated once.

## Test plan
- ADD a = 0x7FFFFFFF, b = 1 -> result 0x80000000, overflow 1, carry_out 0, zero 0, done at cycle 33.
- SUB a = 5, b = 5 -> result 0, zero 1, carry_out 1, overflow 0.
- SLT a = 0xFFFFFFFF, b = 1 -> result 1, done at cycle 65 (33 with `ALU_SEQ_SLT_FAST_EN`). SLT a = 0x80000000, b = 1 -> result 1, overflow 1.
- NOR a = 0, b = 0x0000FFFF -> result 0xFFFF0000. alu_ctl = 101 -> result 0, done at cycle 33.
- `reset` asserted at cycle 10 of an ADD -> next cycle IDLE, `busy` 0, `result` 0, no `done` pulse. `start` pulsed during RUN is ignored.
- `start` held high continuously with ADD 1 + 1 -> `done` pulses every 34 cycles, result 2.
